// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream, line-buffer and window-status bundle for conv_window_ctrl.
// The slave modport is the controller side; master is the driving side.
interface conv_window_ctrl_if #(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 1024,
    parameter int WIDTH = 8
) ();
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic             i_start;
    logic             i_pix_valid;
    logic [WIDTH-1:0] i_pix_data;
    logic             o_pix_ready;
    logic             o_lb_resetn;
    logic             o_lb_wr_valid;
    logic [WIDTH-1:0] o_lb_wr_data;
    logic             o_win_valid;
    logic [RW-1:0]    o_win_row;
    logic [CW-1:0]    o_win_col;
    logic             o_busy;
    logic             o_done;

    modport slave (
        input  i_start, i_pix_valid, i_pix_data,
        output o_pix_ready, o_lb_resetn, o_lb_wr_valid, o_lb_wr_data,
        output o_win_valid, o_win_row, o_win_col, o_busy, o_done
    );

    modport master (
        output i_start, i_pix_valid, i_pix_data,
        input  o_pix_ready, o_lb_resetn, o_lb_wr_valid, o_lb_wr_data,
        input  o_win_valid, o_win_row, o_win_col, o_busy, o_done
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// 3x3 convolution window controller: frame FSM, raster counters, window strobe.
// Define CONV_WINDOW_CTRL_STRIDE2_EN to emit only even-anchored (stride-2) windows.
module conv_window_ctrl #(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 1024,
    parameter int WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    conv_window_ctrl_if.slave bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          lb_resetn_q, lb_resetn_d;
    logic          pix_ready;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          win_hit;

    // Next-state, raster counting and window-strobe generation.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        pix_ready   = 1'b0;
        accept      = 1'b0;
        col_last    = (col_q == CW'(IMG_W - 1));
        row_last    = (row_q == RW'(IMG_H - 1));
        win_hit     = (row_q >= RW'(2)) && (col_q >= CW'(2));
`ifdef CONV_WINDOW_CTRL_STRIDE2_EN
        win_hit     = win_hit && !row_q[0] && !col_q[0];
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                row_d   = '0;
                col_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                pix_ready = 1'b1;
                accept    = bus.i_pix_valid;
                if (accept) begin
                    col_d = col_last ? '0 : col_q + CW'(1);
                    if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
                    // Centre lags the newest pixel by one row and one column.
                    if (win_hit) begin
                        win_valid_d = 1'b1;
                        win_row_d   = row_q - RW'(1);
                        win_col_d   = col_q - CW'(1);
                    end
                    if (row_last && col_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        lb_resetn_d = (state_d != S_CLEAR);
    end

    // State, counters and registered window outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            lb_resetn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            lb_resetn_q <= lb_resetn_d;
        end
    end

    assign bus.o_pix_ready   = pix_ready;
    assign bus.o_lb_wr_valid = accept;
    assign bus.o_lb_wr_data  = bus.i_pix_data;
    assign bus.o_lb_resetn   = lb_resetn_q;
    assign bus.o_win_valid   = win_valid_q;
    assign bus.o_win_row     = win_row_q;
    assign bus.o_win_col     = win_col_q;
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_done        = (state_q == S_DONE);
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl with a raster-index reference model.
// Honours CONV_WINDOW_CTRL_STRIDE2_EN (5x5 image) or default (4x4 image).
module tb_conv_window_ctrl;
`ifdef CONV_WINDOW_CTRL_STRIDE2_EN
    localparam int W      = 5;
    localparam int H      = 5;
    localparam bit STRIDE = 1'b1;
`else
    localparam int W      = 4;
    localparam int H      = 4;
    localparam bit STRIDE = 1'b0;
`endif
    localparam int N      = W * H;
    localparam int BUDGET = 4000;

    typedef struct {
        int row;
        int col;
        bit last;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   done_cnt;
    int   hold_row;
    int   hold_col;
    bit   mon_en;
    exp_t q[$];

    conv_window_ctrl_if #(.IMG_W(W), .IMG_H(H), .WIDTH(8)) bus ();

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIDTH(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the k-th accepted pixel of a frame sits at raster (k/W, k%W).
    function automatic void model_push(input int k);
        int r;
        int c;
        bit ok;
        r  = k / W;
        c  = k % W;
        ok = (r >= 2) && (c >= 2);
        if (STRIDE) ok = ok && (r % 2 == 0) && (c % 2 == 0);
        if (ok) q.push_back('{row: r - 1, col: c - 1, last: (k == N - 1)});
    endfunction

    // Monitor: handshake relation every cycle, windows popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_valid", int'(bus.o_lb_wr_valid),
                int'(bus.i_pix_valid && bus.o_pix_ready));
            if (bus.o_lb_wr_valid)
                chk("wr_data", int'(bus.o_lb_wr_data), int'(bus.i_pix_data));
            if (bus.o_done) done_cnt++;
            if (bus.o_win_valid) begin
                if (q.size() == 0) begin
                    chk("win_extra", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("win_row", int'(bus.o_win_row), e.row);
                    chk("win_col", int'(bus.o_win_col), e.col);
                    chk("win_done", int'(bus.o_done), int'(e.last));
                    hold_row = e.row;
                    hold_col = e.col;
                end
            end else begin
                chk("done_alone", int'(bus.o_done), 0);
                chk("row_hold", int'(bus.o_win_row), hold_row);
                chk("col_hold", int'(bus.o_win_col), hold_col);
            end
        end
    end

    // mode: 0..100 = valid probability in percent, 200 = strict 1/0 toggle.
    task automatic frame(input int mode, input bit hold_start, input int abort_at);
        int n;
        int cyc;
        int target;
        int d0;
        bit v;
        d0     = done_cnt;
        target = (abort_at >= 0) ? abort_at + 1 : N;
        tick();
        bus.i_start     = 1'b1;
        bus.i_pix_valid = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(bus.o_busy), 0);
        chk("idle_ready", int'(bus.o_pix_ready), 0);
        tick();
        if (!hold_start) bus.i_start = 1'b0;
        @(negedge clk);
        chk("clear_lbrst", int'(bus.o_lb_resetn), 0);
        chk("clear_ready", int'(bus.o_pix_ready), 0);
        chk("clear_busy", int'(bus.o_busy), 1);
        tick();
        n   = 0;
        cyc = 0;
        while (cyc < BUDGET) begin
            if (mode == 200) v = (cyc % 2 == 0);
            else v = ($urandom_range(0, 99) < mode);
            bus.i_pix_valid = v;
            bus.i_pix_data  = 8'($urandom);
            @(negedge clk);
            if (cyc == 0) begin
                chk("run_lbrst", int'(bus.o_lb_resetn), 1);
                chk("run_ready", int'(bus.o_pix_ready), 1);
            end
            if (v && bus.o_pix_ready) begin
                model_push(n);
                n++;
            end
            cyc++;
            if (n == target) break;
            tick();
        end
        chk("frame_budget", int'(n == target), 1);
        tick();
        if (abort_at >= 0) begin
            rst             = 1'b1;
            bus.i_pix_valid = 1'b0;
            bus.i_start     = 1'b0;
            tick();
            rst      = 1'b0;
            hold_row = 0;
            hold_col = 0;
            @(negedge clk);
            chk("abort_busy", int'(bus.o_busy), 0);
            chk("abort_ready", int'(bus.o_pix_ready), 0);
            chk("abort_lbrst", int'(bus.o_lb_resetn), 0);
            chk("abort_row", int'(bus.o_win_row), 0);
            for (int i = 0; i < 4; i++) begin
                tick();
                bus.i_pix_valid = 1'b1;
                @(negedge clk);
                chk("abort_idle", int'(bus.o_busy), 0);
            end
            bus.i_pix_valid = 1'b0;
            chk("abort_nodone", done_cnt - d0, 0);
            chk("abort_q", q.size(), 0);
            q.delete();
        end else begin
            bus.i_pix_valid = 1'b1;
            @(negedge clk);
            chk("done_ready", int'(bus.o_pix_ready), 0);
            chk("done_pulse", int'(bus.o_done), 1);
            chk("done_busy", int'(bus.o_busy), 1);
            tick();
            bus.i_start     = 1'b0;
            bus.i_pix_valid = 1'b0;
            @(negedge clk);
            chk("post_busy", int'(bus.o_busy), 0);
            chk("post_done", int'(bus.o_done), 0);
            chk("post_lbrst", int'(bus.o_lb_resetn), 1);
            tick();
            @(negedge clk);
            chk("post_idle", int'(bus.o_busy), 0);
            chk("frame_dones", done_cnt - d0, 1);
            chk("frame_wins", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        done_cnt        = 0;
        hold_row        = 0;
        hold_col        = 0;
        mon_en          = 1'b0;
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_pix_valid = 1'b0;
        bus.i_pix_data  = '0;
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_win", int'(bus.o_win_valid), 0);
        chk("rst_row", int'(bus.o_win_row), 0);
        chk("rst_col", int'(bus.o_win_col), 0);
        chk("rst_lbrst", int'(bus.o_lb_resetn), 0);
        chk("rst_ready", int'(bus.o_pix_ready), 0);
        tick();
        @(negedge clk);
        chk("idle_lbrst", int'(bus.o_lb_resetn), 1);
        frame(100, 1'b0, -1);
        frame(200, 1'b0, -1);
        frame(50, 1'b0, -1);
        frame(70, 1'b1, -1);
        frame(100, 1'b0, 9);
        frame(100, 1'b0, -1);
        for (int i = 0; i < 6; i++)
            frame(int'($urandom_range(20, 95)), 1'($urandom_range(0, 1)), -1);
        frame(60, 1'b0, int'($urandom_range(0, N - 2)));
        frame(100, 1'b0, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 1024, pixels per row (>=3); also the line-buffer DEPTH.
REQ-002 SHALL have parameter IMG_H, default 1024, rows per frame (>=3).
REQ-003 SHALL have parameter WIDTH, default 8, pixel bit width.
REQ-004 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  frame start request, honoured only in IDLE.
REQ-007 SHALL have port i_pix_valid  input  1  upstream pixel valid.
REQ-008 SHALL have port i_pix_data  input  WIDTH  upstream pixel.
REQ-009 SHALL have port o_pix_ready  output  1  controller accepts a pixel this cycle.
REQ-010 SHALL have port o_lb_resetn  output  1  active-low synchronous reset to both line buffers.
REQ-011 SHALL have port o_lb_wr_valid  output  1  write strobe to the line-buffer chain.
REQ-012 SHALL have port o_lb_wr_data  output  WIDTH  write data to the line-buffer chain.
REQ-013 SHALL have port o_win_valid  output  1  a full 3x3 window is present at the window register.
REQ-014 SHALL have port o_win_row  output  $clog2(IMG_H)  window centre row.
REQ-015 SHALL have port o_win_col  output  $clog2(IMG_W)  window centre column.
REQ-016 SHALL have port o_busy  output  1  high in CLEAR, RUN, DONE.
REQ-017 SHALL have port o_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-018 SHALL implement states IDLE, CLEAR, RUN, DONE.
REQ-019 IDLE: o_pix_ready=0; i_start=1 -> CLEAR next cycle; otherwise stay.
REQ-020 CLEAR lasts exactly one cycle: o_lb_resetn=0, o_pix_ready=0, row/col counters zeroed -> RUN.
REQ-021 RUN: o_pix_ready=1 combinationally; accept = i_pix_valid && o_pix_ready.
REQ-022 o_lb_wr_valid SHALL equal accept and o_lb_wr_data SHALL equal i_pix_data, combinationally, zero latency.
REQ-023 On accept: col+1; at col==IMG_W-1 col wraps to 0 and row+1; no change without accept.
REQ-024 On accept with row>=2 and col>=2: o_win_valid=1 on the next cycle, o_win_row=row-1, o_win_col=col-1 (registered, matching the line-buffer 1-cycle read latency).
REQ-025 o_win_valid SHALL be 0 in every other cycle; o_win_row/o_win_col hold their last value when not valid.
REQ-026 Accept at row==IMG_H-1, col==IMG_W-1 -> DONE next cycle; o_pix_ready drops in that same next cycle.
REQ-027 DONE lasts exactly one cycle with o_done=1 (coinciding with the final o_win_valid), then IDLE.
REQ-028 i_start outside IDLE SHALL be ignored; i_pix_valid outside RUN SHALL be ignored (no write, no count).
REQ-029 Upstream stalls (i_pix_valid=0) in RUN SHALL freeze counters and produce no window pulse.
REQ-030 o_lb_resetn SHALL be 1 in all states except CLEAR and reset.

Reset
REQ-031 i_reset=1 at a rising edge SHALL force IDLE, counters 0, o_win_valid=0, o_done=0, o_win_row=0, o_win_col=0, o_lb_resetn=0.
REQ-032 Reset mid-frame SHALL discard the frame; no o_done; next frame requires i_start.
REQ-033 Outputs SHALL be defined (no X) from the first cycle after reset.

Configuration
REQ-034 Macro CONV_WINDOW_CTRL_STRIDE2_EN defined: o_win_valid additionally requires row and col of the accepted pixel both even (stride-2 windows, top-left anchored at even coordinates); counters, handshake, o_done unchanged.
REQ-035 Macro undefined: stride-1 behaviour of REQ-024, every window emitted.

Verification
REQ-036 IMG_W=4, IMG_H=4, start then 16 back-to-back pixels 0..15 -> o_pix_ready high 16 cycles, 4 win pulses with (row,col)=(1,1),(1,2),(2,1),(2,2), o_done with final pulse.
REQ-037 Same frame with i_pix_valid toggled 1/0 -> identical 4 windows, each 1 cycle after its 11th/12th/15th/16th accept; counters frozen on idle cycles.
REQ-038 i_start held high through RUN and DONE -> only one frame; after DONE, IDLE then CLEAR on next start, o_lb_resetn low exactly 1 cycle.
REQ-039 i_reset asserted after pixel 9 -> IDLE next cycle, no o_done, no further win pulses; new frame of 16 -> 4 windows as REQ-036.
REQ-040 CONV_WINDOW_CTRL_STRIDE2_EN, IMG_W=5, IMG_H=5, 25 pixels -> exactly 4 win pulses at (1,1),(1,3),(3,1),(3,3).
REQ-041 i_pix_valid=1 while IDLE/CLEAR/DONE -> o_lb_wr_valid stays 0, counters unchanged.
